// File: rtl/demux_8_router.sv
// 1-to-8 demultiplexing router: each input word is parked in a per-channel
// holding register until that channel's consumer acknowledges it.
module demux_8_router #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ack,
    output logic [7:0]       accept_count
);

    logic [2:0]       sel;
    logic             accept;
    logic [7:0]       load_ch;
    logic [7:0]       consume_ch;
    logic [7:0]       valid_reg;
    logic [7:0]       valid_next;
    logic [7:0]       count_reg;
    logic [WIDTH-1:0] data_reg [8];

    assign sel = {s2, s1, s0};

    // Ready looks only at registered state, so out_ack never reaches in_ready.
    assign in_ready = ~valid_reg[sel];
    assign accept   = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            assign load_ch[gi]    = accept && (sel == 3'(gi));
            assign consume_ch[gi] = valid_reg[gi] & out_ack[gi];
            assign valid_next[gi] = load_ch[gi] | (valid_reg[gi] & ~consume_ch[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            count_reg <= '0;
            for (int i = 0; i < 8; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            if (accept) begin
                count_reg <= count_reg + 8'd1;
            end
            // Data is only written on a load; a consume leaves the last word in place.
            for (int i = 0; i < 8; i++) begin
                if (load_ch[i]) begin
                    data_reg[i] <= in_data;
                end
            end
        end
    end

    assign out_valid    = valid_reg;
    assign accept_count = count_reg;

    assign a = data_reg[0];
    assign b = data_reg[1];
    assign c = data_reg[2];
    assign d = data_reg[3];
    assign e = data_reg[4];
    assign f = data_reg[5];
    assign g = data_reg[6];
    assign h = data_reg[7];

endmodule

// File: tb/tb_demux_8_router.sv
// Scoreboard bench for demux_8_router: stimulus pushes expected words per
// channel, a negedge monitor pops and compares on every consume.
module tb_demux_8_router;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         s0, s1, s2;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]   out_valid;
    logic [7:0]   out_ack;
    logic [7:0]   accept_count;

    logic [W-1:0] ch_out [8];
    logic [W-1:0] exp_q  [8][$];
    logic [W-1:0] mon_word;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_8_router #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .s0(s0), .s1(s1), .s2(s2),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ack(out_ack), .accept_count(accept_count)
    );

    assign ch_out[0] = a;
    assign ch_out[1] = b;
    assign ch_out[2] = c;
    assign ch_out[3] = d;
    assign ch_out[4] = e;
    assign ch_out[5] = f;
    assign ch_out[6] = g;
    assign ch_out[7] = h;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int ch);
        logic [2:0] s;
        s = 3'(ch);
        {s2, s1, s0} = s;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 8; i++) exp_q[i].delete();
    endtask

    // Monitor: every consume must deliver the oldest expected word of that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                if (out_valid[i] && out_ack[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word ch%0d: got %h required none", i, ch_out[i]);
                    end else begin
                        mon_word = exp_q[i].pop_front();
                        check($sformatf("consume_ch%0d", i), 32'(ch_out[i]), 32'(mon_word));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] dw;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ack = '0;
        {s2, s1, s0} = 3'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'h00);
        check("rst_count", 32'(accept_count), 32'h00);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rst_ch%0d", i), 32'(ch_out[i]), 32'h0);
            set_sel(i);
            #1;
            check($sformatf("rst_ready_sel%0d", i), 32'(in_ready), 32'h1);
        end

        // Single word to channel 3
        set_sel(3); in_data = 16'hBEEF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q[3].push_back(16'hBEEF);
        check("basic_d", 32'(d), 32'hBEEF);
        check("basic_out_valid", 32'(out_valid), 32'h08);
        check("basic_count", 32'(accept_count), 32'h01);
        for (int i = 0; i < 8; i++)
            if (i != 3) check($sformatf("basic_other_ch%0d", i), 32'(ch_out[i]), 32'h0);
        out_ack = 8'h08;
        tick();
        out_ack = 8'h00;
        check("consumed_valid", 32'(out_valid), 32'h00);
        check("retain_d", 32'(d), 32'hBEEF);

        // Stall on full channel 5, ack releases it one cycle later
        set_sel(5); in_data = 16'h5555; in_valid = 1'b1;
        tick();
        exp_q[5].push_back(16'h5555);
        in_data = 16'h1234;
        #1;
        check("stall_ready", 32'(in_ready), 32'h0);
        tick();
        check("stall_f", 32'(f), 32'h5555);
        check("stall_count", 32'(accept_count), 32'h02);
        out_ack = 8'h20;
        #1;
        check("ack_no_comb_ready", 32'(in_ready), 32'h0);
        tick();
        out_ack = 8'h00;
        check("after_ack_valid5", 32'(out_valid[5]), 32'h0);
        check("after_ack_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        exp_q[5].push_back(16'h1234);
        check("late_accept_f", 32'(f), 32'h1234);
        check("late_accept_valid5", 32'(out_valid[5]), 32'h1);
        check("late_accept_count", 32'(accept_count), 32'h03);

        // Accept ch0 while consuming ch7 in the same cycle
        set_sel(7); in_data = 16'h7777; in_valid = 1'b1;
        tick();
        exp_q[7].push_back(16'h7777);
        set_sel(0); in_data = 16'h00AA; out_ack = 8'h80;
        tick();
        exp_q[0].push_back(16'h00AA);
        in_valid = 1'b0; out_ack = 8'h00;
        check("same_cycle_valid0", 32'(out_valid[0]), 32'h1);
        check("same_cycle_valid7", 32'(out_valid[7]), 32'h0);
        check("same_cycle_a", 32'(a), 32'h00AA);

        // Ack of an empty channel with no offer changes nothing
        out_ack = 8'h04;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("idle_out_valid", 32'(out_valid), 32'h21);
            check("idle_count", 32'(accept_count), 32'h05);
            check("idle_c", 32'(c), 32'h0);
        end
        out_ack = 8'h21;
        tick();
        out_ack = 8'h00;
        check("drain_valid", 32'(out_valid), 32'h00);

        // Counter wrap: 256 accepts with acks one cycle behind
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_queues();
        for (int k = 0; k < 256; k++) begin
            dw = 16'(k * 37 + 5);
            set_sel(k % 8); in_data = dw; in_valid = 1'b1;
            out_ack = (k > 0) ? (8'h01 << ((k - 1) % 8)) : 8'h00;
            #1;
            check("wrap_ready", 32'(in_ready), 32'h1);
            exp_q[k % 8].push_back(dw);
            tick();
        end
        in_valid = 1'b0; out_ack = 8'h00;
        check("wrap_count0", 32'(accept_count), 32'h00);
        set_sel(0); in_data = 16'hC0DE; in_valid = 1'b1; out_ack = 8'h80;
        tick();
        exp_q[0].push_back(16'hC0DE);
        in_valid = 1'b0; out_ack = 8'h01;
        check("wrap_count1", 32'(accept_count), 32'h01);
        tick();
        out_ack = 8'h00;
        check("wrap_drain", 32'(out_valid), 32'h00);

        // Fill all channels, then reset while an offer and an ack are pending
        for (int i = 0; i < 8; i++) begin
            dw = 16'(16'hA0 + i);
            set_sel(i); in_data = dw; in_valid = 1'b1;
            tick();
            exp_q[i].push_back(dw);
        end
        check("full_valid", 32'(out_valid), 32'hFF);
        rst = 1'b1; set_sel(2); in_data = 16'hDEAD; out_ack = 8'h01;
        tick();
        rst = 1'b0; out_ack = 8'h00;
        clear_queues();
        check("mid_rst_valid", 32'(out_valid), 32'h00);
        check("mid_rst_count", 32'(accept_count), 32'h00);
        check("mid_rst_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 8; i++)
            check($sformatf("mid_rst_ch%0d", i), 32'(ch_out[i]), 32'h0);
        in_valid = 1'b0;
        tick(); tick();

        for (int i = 0; i < 8; i++)
            check($sformatf("queue_empty_ch%0d", i), 32'(exp_q[i].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
